if_id_buffer: RTL and testbench
===============================

# if_id_buffer

Two-entry instruction buffer between instruction fetch and decode. Accepts fetched instruction words with their PC over a valid/ready handshake and presents the oldest word to decode. It also slices the word into MIPS-format fields; `out_imm` feeds the sign-extension unit directly. It decouples fetch stalls from decode stalls, supports a pipeline flush, and sustains one instruction per cycle.

## Interface
- `PC_W`, default 32: width of the program-counter field carried with each instruction.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: fetch presents a word this cycle.
- `in_ready` out 1: buffer can accept a word this cycle.
- `in_instr` in 32: fetched instruction word.
- `in_pc` in PC_W: address of `in_instr`.
- `flush` in 1: discard all buffered and incoming words (branch/jump redirect).
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: decode consumes the head entry this cycle.
- `out_instr` out 32: head instruction word.
- `out_pc` out PC_W: head PC.
- `out_opcode` out 6: `out_instr[31:26]`.
- `out_rs` out 5: `out_instr[25:21]`.
- `out_rt` out 5: `out_instr[20:16]`.
- `out_rd` out 5: `out_instr[15:11]`.
- `out_shamt` out 5: `out_instr[10:6]`.
- `out_funct` out 6: `out_instr[5:0]`.
- `out_imm` out 16: `out_instr[15:0]`, raw and unextended, destined for sign extension.
- `out_target` out 26: `out_instr[25:0]`.

## Operation
- Storage: 2 entries of {instr, pc}, circular, with 1-bit write pointer, 1-bit read pointer, and a 2-bit count (0..2).
- Push = `in_valid & in_ready`. Pop = `out_valid & out_ready`.
- `in_ready` = (count != 2). It is a function of registered state only; there is no combinational path from `out_ready`.
- `out_valid` = (count != 0).
- Push writes the entry at wptr; wptr toggles. Pop advances rptr (toggles).
- Count update:
  - push only: +1.
  - pop only: −1.
  - both: unchanged.
  - Both pushing and popping at count 2 is impossible, since `in_ready` = 0.
- Strict FIFO order. Pointers wrap 1→0 with no bubble.
- Flush has priority over push and pop:
  - Next cycle count = 0 and wptr = rptr = 0.
  - A word offered in the flush cycle is dropped, even if `in_ready` = 1.
  - `in_ready` is not gated by `flush`.
- Output view:
  - When `out_valid` = 1, `out_instr`/`out_pc` are the entry at rptr.
  - When `out_valid` = 0, `out_instr` = 32'h0000_0000 (NOP) and `out_pc` = 0.
  - All field outputs are pure slices of `out_instr`, so they are all zero when empty.
- Reset: count = 0, pointers = 0, storage cleared to 0. Reset overrides `flush` and all handshakes.
- Reset mid-operation discards buffered words identically to flush.

## Timing
- Reset values:
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `out_instr`, `out_pc`, and all fields = 0.
- Latency: a word pushed in cycle N appears on `out_*` with `out_valid` = 1 in cycle N+1. There is no same-cycle bypass.
- Throughput: with `out_ready` held 1, one word per cycle in steady state at count = 1.
- Backpressure:
  - With `out_ready` = 0, two consecutive pushes fill the buffer.
  - `in_ready` falls in the cycle after the second push.
  - The first pop at count 2 raises `in_ready` in the next cycle.
- Head outputs are stable while `out_valid` = 1 and `out_ready` = 0.
- Flush asserted in cycle N: `out_valid` = 0 in cycle N+1. A push in N+1 is visible in N+2.

## Test plan
- Reset, then push `in_instr`=32'h2108_FFFC, `in_pc`=32'h0000_0040. Next cycle:
  - `out_valid` = 1.
  - `out_opcode` = 6'h08, `out_rs` = 8, `out_rt` = 8.
  - `out_imm` = 16'hFFFC, `out_pc` = 32'h40.
  - After a pop, `out_instr` = 0 and all fields are zero.
- Hold `out_ready` = 0 and push A=32'h1111_1111, then B=32'h2222_2222:
  - `in_ready` = 0 after B.
  - A third word C offered while full is not accepted.
  - Raising `out_ready` yields A, then B, then C once C is re-offered. Order is preserved.
- At count 1 (head A), push B and pop A in the same cycle: count stays 1 and the head becomes B next cycle.
- Stream 7 sequential words with PCs 0x0, 0x4, …, 0x18 while `out_ready` toggles on alternating cycles: all 7 emerge in order across pointer wrap, with no loss or duplication.
- At count 2, assert `flush` while `in_valid` = 1 with word D:
  - Next cycle `out_valid` = 0 and `in_ready` = 1.
  - D never appears.
  - A word pushed afterwards appears with 1-cycle latency.
- Assert `rst` mid-stream at count 2 together with `flush` and `in_valid`: next cycle matches the reset values, and no buffered word appears.

Source files
------------

// File: rtl/if_id_buffer.sv
// Two-entry IF/ID instruction buffer: decouples fetch and decode stalls,
// presents the oldest {instr, pc} and its MIPS field slices, and supports flush.
module if_id_buffer #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  // Handshakes: a word moves only in a cycle where valid and ready are both 1.
  // Valid never depends on ready; in_ready/out_valid depend only on registered state.
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [5:0]      out_opcode,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_shamt,
  output logic [5:0]      out_funct,
  output logic [15:0]     out_imm,
  output logic [25:0]     out_target
);

  logic [31:0]     mem_instr [2];
  logic [PC_W-1:0] mem_pc    [2];
  logic            wptr;
  logic            rptr;
  logic [1:0]      count;
  logic            push;
  logic            pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (flush) begin
      // Redirect: drop everything, including a word offered this cycle.
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem_instr[wptr] <= in_instr;
        mem_pc[wptr]    <= in_pc;
        wptr            <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      if (push && !pop) begin
        count <= count + 2'd1;
      end else if (pop && !push) begin
        count <= count - 2'd1;
      end
    end
  end

  // Empty buffer presents a NOP so downstream fields read as zero.
  assign out_instr  = out_valid ? mem_instr[rptr] : 32'h0000_0000;
  assign out_pc     = out_valid ? mem_pc[rptr]    : '0;
  assign out_opcode = out_instr[31:26];
  assign out_rs     = out_instr[25:21];
  assign out_rt     = out_instr[20:16];
  assign out_rd     = out_instr[15:11];
  assign out_shamt  = out_instr[10:6];
  assign out_funct  = out_instr[5:0];
  assign out_imm    = out_instr[15:0];
  assign out_target = out_instr[25:0];

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for if_id_buffer: reset, field slicing,
// backpressure, simultaneous push/pop, streaming across wrap, flush and reset.
module tb_if_id_buffer;

  localparam int PC_W = 32;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc;
  logic [5:0]      out_opcode;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [4:0]      out_rd;
  logic [4:0]      out_shamt;
  logic [5:0]      out_funct;
  logic [15:0]     out_imm;
  logic [25:0]     out_target;

  int errors = 0;
  int checks = 0;

  if_id_buffer #(.PC_W(PC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_imm(out_imm), .out_target(out_target)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [PC_W-1:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    cycle();
    cycle();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    checks++; if (out_target !== 26'h0) begin errors++; $display("FAIL reset_out_target got=%h exp=0", out_target); end
  endtask

  task automatic test_fields();
    push_one(32'h2108_FFFC, 32'h0000_0040);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fields_valid got=%b exp=1", out_valid); end
    checks++; if (out_opcode !== 6'h08) begin errors++; $display("FAIL fields_opcode got=%h exp=08", out_opcode); end
    checks++; if (out_rs !== 5'd8) begin errors++; $display("FAIL fields_rs got=%0d exp=8", out_rs); end
    checks++; if (out_rt !== 5'd8) begin errors++; $display("FAIL fields_rt got=%0d exp=8", out_rt); end
    checks++; if (out_rd !== 5'h1F) begin errors++; $display("FAIL fields_rd got=%h exp=1f", out_rd); end
    checks++; if (out_shamt !== 5'h1F) begin errors++; $display("FAIL fields_shamt got=%h exp=1f", out_shamt); end
    checks++; if (out_funct !== 6'h3C) begin errors++; $display("FAIL fields_funct got=%h exp=3c", out_funct); end
    checks++; if (out_imm !== 16'hFFFC) begin errors++; $display("FAIL fields_imm got=%h exp=fffc", out_imm); end
    checks++; if (out_target !== 26'h108FFFC) begin errors++; $display("FAIL fields_target got=%h exp=108fffc", out_target); end
    checks++; if (out_pc !== 32'h40) begin errors++; $display("FAIL fields_pc got=%h exp=40", out_pc); end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pop_valid got=%b exp=0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL pop_instr got=%h exp=0", out_instr); end
    checks++; if (out_opcode !== 6'h0 || out_imm !== 16'h0 || out_rs !== 5'h0 || out_funct !== 6'h0)
      begin errors++; $display("FAIL pop_fields got=%h/%h/%h/%h exp=0", out_opcode, out_rs, out_imm, out_funct); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push_one(32'h1111_1111, 32'h100);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_a got=%b exp=1", in_ready); end
    push_one(32'h2222_2222, 32'h104);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after_b got=%b exp=0", in_ready); end
    push_one(32'h3333_3333, 32'h108);
    checks++; if (out_instr !== 32'h1111_1111) begin errors++; $display("FAIL bp_head_stable got=%h exp=11111111", out_instr); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_still_full got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    cycle();
    checks++; if (out_instr !== 32'h2222_2222) begin errors++; $display("FAIL bp_second got=%h exp=22222222", out_instr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got=%b exp=1", in_ready); end
    cycle();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_c_dropped got=%b exp=0", out_valid); end
    push_one(32'h3333_3333, 32'h108);
    checks++; if (out_instr !== 32'h3333_3333 || out_pc !== 32'h108)
      begin errors++; $display("FAIL bp_third got=%h/%h exp=33333333/108", out_instr, out_pc); end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_push_pop_same_cycle();
    push_one(32'hAAAA_0001, 32'h200);
    in_valid = 1'b1; in_instr = 32'hBBBB_0002; in_pc = 32'h204; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'hBBBB_0002)
      begin errors++; $display("FAIL pp_head got=%b/%h exp=1/bbbb0002", out_valid, out_instr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pp_count_one got=%b exp=1", in_ready); end
    push_one(32'hCCCC_0003, 32'h208);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pp_now_full got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    cycle();
    checks++; if (out_instr !== 32'hCCCC_0003) begin errors++; $display("FAIL pp_drain got=%h exp=cccc0003", out_instr); end
    cycle();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pp_empty got=%b exp=0", out_valid); end
  endtask

  // Scoreboard: expected words queued at push time, popped and compared at consume time.
  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    int sent = 0;
    int got = 0;
    for (int cyc = 0; cyc < 60 && got < 7; cyc++) begin
      out_ready = cyc[0];
      in_valid  = (sent < 7);
      in_instr  = 32'hA000_0000 | 32'(sent);
      in_pc     = 32'(sent * 4);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra got=%h exp=none", out_instr);
        end else begin
          exp_w = exp_q.pop_front();
          if (out_instr !== exp_w || out_pc !== ((exp_w & 32'hFF) << 2)) begin
            errors++; $display("FAIL stream_word got=%h/%h exp=%h/%h", out_instr, out_pc, exp_w, (exp_w & 32'hFF) << 2);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_instr);
        sent++;
      end
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (got != 7) begin errors++; $display("FAIL stream_count got=%0d exp=7", got); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_dup got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    push_one(32'h1111_AAAA, 32'h300);
    push_one(32'h2222_BBBB, 32'h304);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'hDDDD_DDDD; in_pc = 32'h308;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_full got=%b/%b exp=0/1", out_valid, in_ready); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL flush_nop got=%h exp=0", out_instr); end
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_d_dropped got=%b exp=0", out_valid); end
    // Flush at count 1 with in_ready=1 must still drop the offered word.
    push_one(32'h4444_0000, 32'h400);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'hDDDD_0001; in_pc = 32'h404;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_open_drop got=%b exp=0", out_valid); end
    push_one(32'hEEEE_0005, 32'h500);
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'hEEEE_0005 || out_pc !== 32'h500)
      begin errors++; $display("FAIL flush_repush got=%b/%h/%h exp=1/eeee0005/500", out_valid, out_instr, out_pc); end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_repush_pop got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    push_one(32'h5555_0001, 32'h600);
    push_one(32'h5555_0002, 32'h604);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_instr = 32'h6666_0003; in_pc = 32'h608;
    cycle();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL rst_mid_hs got=%b/%b exp=1/0", in_ready, out_valid); end
    checks++; if (out_instr !== 32'h0 || out_pc !== 32'h0)
      begin errors++; $display("FAIL rst_mid_out got=%h/%h exp=0/0", out_instr, out_pc); end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_word got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_fields();
    test_backpressure();
    test_push_pop_same_cycle();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
